// File: rtl/apb_master_if.sv
// apb_master_if -- bundles the CPU request/response handshake and the APB
// completer-side bus of apb_master into one interface.
//   modport master : the view used by apb_master (drives req_ready, rsp_*, p*)
//   modport slave  : the view used by whoever sits around the master (CPU side
//                    and completer), driving req_* inputs and prdata/pready/perr
// Signals:
//   req_valid/req_ready/req_addr/req_wdata/req_write/req_size/req_unsigned
//   rsp_valid/rsp_rdata/rsp_err
//   paddr/pdata/prdata/psel/penable/pwrite/pstb/pready/perr
interface apb_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [3:0]            pstb;
  logic                  pready;
  logic                  perr;

  modport master (
    input  req_valid, req_addr, req_wdata, req_write, req_size, req_unsigned,
    input  prdata, pready, perr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output paddr, pdata, psel, penable, pwrite, pstb
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_write, req_size, req_unsigned,
    output prdata, pready, perr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  paddr, pdata, psel, penable, pwrite, pstb
  );
endinterface

// File: rtl/apb_master.sv
// apb_master -- turns single CPU load/store requests into APB transfers.
// Byte/half/word accesses are lane-aligned onto the 32-bit bus with strobes,
// load data is shifted back down and zero/sign-extended. Misaligned requests
// are answered with an error without touching the bus; a completer that never
// raises pready is abandoned after TIMEOUT ACCESS cycles.
// Ports:
//   pclk : clock, rising edge
//   prst : asynchronous active-high reset
//   bus  : apb_master_if.master (request, response and APB signals)
module apb_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic         pclk,
  input  logic         prst,
  apb_master_if.master bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pdata_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [3:0]            pstb_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic                  accept_d;
  logic                  misalign_d;
  logic [3:0]            strb_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [DATA_WIDTH-1:0] rdata_d;

  // Expands a 4-bit byte strobe into a 32-bit lane mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

  // Truncates right-aligned load data to the access size and extends it.
  function automatic logic [31:0] load_extend(input logic [31:0] sh,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [31:0] r;
    case (size)
      2'b00:   r = uns ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   r = uns ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
      2'b10:   r = sh;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Request decode (alignment, strobes, lane-shifted store data) and load
  // data extraction from the registered address/size.
  always_comb begin
    accept_d = bus.req_valid & req_ready_q;
    case (bus.req_size)
      2'b00: begin
        misalign_d = 1'b0;
        strb_d     = 4'b0001 << bus.req_addr[1:0];
      end
      2'b01: begin
        misalign_d = bus.req_addr[0];
        strb_d     = 4'b0011 << bus.req_addr[1:0];
      end
      2'b10: begin
        misalign_d = (bus.req_addr[1:0] != 2'b00);
        strb_d     = 4'b1111;
      end
      default: begin
        misalign_d = 1'b1;
        strb_d     = 4'b0000;
      end
    endcase
    // Unused lanes are forced to zero so upper store-data garbage never leaks.
    wdata_d = (bus.req_wdata << {bus.req_addr[1:0], 3'b000}) & lane_mask(strb_d);
    rdata_d = load_extend(bus.prdata >> {paddr_q[1:0], 3'b000}, size_q, uns_q);
  end

  // Transfer FSM; every output is a register updated alongside the state.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      paddr_q     <= '0;
      pdata_q     <= '0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pstb_q      <= 4'b0000;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            req_ready_q <= 1'b0;
            paddr_q     <= bus.req_addr;
            size_q      <= bus.req_size;
            uns_q       <= bus.req_unsigned;
            if (misalign_d) begin
              state_q     <= RESP;
              pdata_q     <= '0;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q  <= SETUP;
              psel_q   <= 1'b1;
              pwrite_q <= bus.req_write;
              pstb_q   <= strb_d;
              pdata_q  <= wdata_d;
            end
          end else begin
            // Also raises ready on the first clock after reset release.
            req_ready_q <= 1'b1;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
          cnt_q     <= '0;
        end
        ACCESS: begin
          // pready wins over an expiring timeout in the same cycle.
          if (bus.pready || (cnt_q == CNT_LAST)) begin
            state_q     <= RESP;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pstb_q      <= 4'b0000;
            rsp_valid_q <= 1'b1;
            cnt_q       <= '0;
            if (bus.pready && !bus.perr) begin
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= pwrite_q ? '0 : rdata_d;
            end else begin
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q   <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.paddr     = paddr_q;
  assign bus.pdata     = pdata_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pstb      = pstb_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master -- directed bench for apb_master. Each request pushes its
// expected response onto a scoreboard queue; the response pulse pops it.
// The bench also plays the completer with a programmable number of wait cycles.
module tb_apb_master;

  logic pclk = 1'b0;
  logic prst;

  apb_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .pclk (pclk),
    .prst (prst),
    .bus  (bus)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request (called at a negedge) and follows it to its response.
  task automatic run_req(input string       name,
                         input logic [31:0] addr,
                         input logic [31:0] wdata,
                         input logic        wr,
                         input logic [1:0]  size,
                         input logic        uns,
                         input int          wait_n,
                         input logic [31:0] prd,
                         input logic        perr_in,
                         input logic [31:0] exp_rdata,
                         input logic        exp_err,
                         input logic [3:0]  exp_strb,
                         input logic [31:0] exp_pdata,
                         input int          exp_psel,
                         input int          exp_lat);
    int   psel_n;
    int   acc_n;
    logic got;
    exp_t e;
    chk({name, ".ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_write    = wr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb.push_back(e);
    @(posedge pclk);
    @(negedge pclk);
    // Scramble the request lines: the accepted transfer must not follow them.
    bus.req_valid    = 1'b0;
    bus.req_addr     = ~addr;
    bus.req_wdata    = ~wdata;
    bus.req_write    = ~wr;
    bus.req_size     = ~size;
    bus.req_unsigned = ~uns;
    psel_n = 0;
    acc_n  = 0;
    got    = 1'b0;
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      if (bus.psel) begin
        psel_n++;
        chk({name, ".paddr"},  bus.paddr,         addr);
        chk({name, ".pstb"},   32'(bus.pstb),     32'(exp_strb));
        chk({name, ".pdata"},  bus.pdata,         exp_pdata);
        chk({name, ".pwrite"}, 32'(bus.pwrite),   32'(wr));
        if (bus.penable) begin
          acc_n++;
        end
      end
      if (bus.penable && (acc_n > wait_n)) begin
        bus.pready = 1'b1;
        bus.perr   = perr_in;
        bus.prdata = prd;
      end else begin
        bus.pready = 1'b0;
        bus.perr   = 1'b0;
        bus.prdata = $urandom();
      end
      if (bus.rsp_valid) begin
        got = 1'b1;
        chk({name, ".latency"},  32'(cyc),        32'(exp_lat));
        chk({name, ".resp_psel"}, 32'({bus.psel, bus.penable, bus.pwrite, bus.pstb}), 32'd0);
        chk({name, ".sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({name, ".rdata"}, bus.rsp_rdata,    e.rdata);
          chk({name, ".err"},   32'(bus.rsp_err), 32'(e.err));
        end
      end
      @(posedge pclk);
      @(negedge pclk);
    end
    bus.pready = 1'b0;
    bus.perr   = 1'b0;
    chk({name, ".rsp_seen"},   32'(got),           32'd1);
    chk({name, ".psel_cycles"}, 32'(psel_n),       32'(exp_psel));
    chk({name, ".pulse_end"},  32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    prst             = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.prdata       = 32'h0;
    bus.pready       = 1'b0;
    bus.perr         = 1'b0;
    repeat (2) @(negedge pclk);
    chk("rst.ready",   32'(bus.req_ready), 32'd0);
    chk("rst.bus",     32'({bus.psel, bus.penable, bus.pwrite, bus.pstb}), 32'd0);
    chk("rst.rsp",     32'({bus.rsp_valid, bus.rsp_err}), 32'd0);
    chk("rst.rdata",   bus.rsp_rdata, 32'd0);
    chk("rst.paddr",   bus.paddr,     32'd0);
    chk("rst.pdata",   bus.pdata,     32'd0);
    prst = 1'b0;
    @(posedge pclk);
    @(negedge pclk);

    //       name        addr          wdata         wr    size   uns   wt   prdata        perr  exp_rdata     err   strb     pdata         psel lat
    run_req("st_word",  32'h10,       32'hDEADBEEF, 1'b1, 2'b10, 1'b0, 1,   32'h0,        1'b0, 32'h0,        1'b0, 4'b1111, 32'hDEADBEEF, 3,   4);
    run_req("ld_byte_s",32'h13,       32'h0,        1'b0, 2'b00, 1'b0, 0,   32'h80123456, 1'b0, 32'hFFFFFF80, 1'b0, 4'b1000, 32'h0,        2,   3);
    run_req("ld_byte_u",32'h13,       32'h0,        1'b0, 2'b00, 1'b1, 0,   32'h80123456, 1'b0, 32'h00000080, 1'b0, 4'b1000, 32'h0,        2,   3);
    run_req("st_half",  32'h22,       32'h0000BEEF, 1'b1, 2'b01, 1'b0, 0,   32'h0,        1'b0, 32'h0,        1'b0, 4'b1100, 32'hBEEF0000, 2,   3);
    run_req("mis_half", 32'h21,       32'h00001234, 1'b1, 2'b01, 1'b0, 0,   32'h0,        1'b0, 32'h0,        1'b1, 4'b0000, 32'h0,        0,   1);
    run_req("mis_size", 32'h0,        32'h0,        1'b0, 2'b11, 1'b0, 0,   32'h0,        1'b0, 32'h0,        1'b1, 4'b0000, 32'h0,        0,   1);
    run_req("mis_word", 32'h2,        32'h0,        1'b0, 2'b10, 1'b1, 0,   32'h0,        1'b0, 32'h0,        1'b1, 4'b0000, 32'h0,        0,   1);
    run_req("timeout",  32'h40,       32'h0,        1'b0, 2'b10, 1'b0, 100, 32'h0,        1'b0, 32'h0,        1'b1, 4'b1111, 32'h0,        17,  18);
    run_req("perr_ld",  32'h44,       32'h0,        1'b0, 2'b10, 1'b0, 0,   32'h12345678, 1'b1, 32'h0,        1'b1, 4'b1111, 32'h0,        2,   3);
    run_req("perr_st",  32'h31,       32'hFFFFFFA5, 1'b1, 2'b00, 1'b0, 2,   32'h0,        1'b1, 32'h0,        1'b1, 4'b0010, 32'h0000A500, 4,   5);
    run_req("ld_half_s",32'h46,       32'h0,        1'b0, 2'b01, 1'b0, 0,   32'h80015555, 1'b0, 32'hFFFF8001, 1'b0, 4'b1100, 32'h0,        2,   3);
    run_req("ld_half_u",32'h0,        32'h0,        1'b0, 2'b01, 1'b1, 0,   32'h1234F00D, 1'b0, 32'h0000F00D, 1'b0, 4'b0011, 32'h0,        2,   3);
    run_req("ld_byte1", 32'h1,        32'h0,        1'b0, 2'b00, 1'b0, 0,   32'h00007F00, 1'b0, 32'h0000007F, 1'b0, 4'b0010, 32'h0,        2,   3);
    run_req("ld_word_w",32'h8,        32'h0,        1'b0, 2'b10, 1'b0, 3,   32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0, 4'b1111, 32'h0,        5,   6);

    // Reset pulse during ACCESS: the transfer vanishes with no response.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h50;
    bus.req_write = 1'b0;
    bus.req_size  = 2'b10;
    @(posedge pclk);
    @(negedge pclk);
    bus.req_valid = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    chk("abort.in_access", 32'({bus.psel, bus.penable}), 32'd3);
    prst = 1'b1;
    #1;
    chk("abort.psel",    32'({bus.psel, bus.penable}), 32'd0);
    chk("abort.ready",   32'(bus.req_ready), 32'd0);
    repeat (2) begin
      @(negedge pclk);
      chk("abort.no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    prst = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    chk("abort.ready_after", 32'(bus.req_ready), 32'd1);
    chk("abort.no_rsp_after", 32'(bus.rsp_valid), 32'd0);
    run_req("post_rst", 32'h60,       32'h01020304, 1'b1, 2'b10, 1'b0, 0,   32'h0,        1'b0, 32'h0,        1'b0, 4'b1111, 32'h01020304, 2,   3);
    chk("sb.drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, bus address width.
REQ-002 Parameter DATA_WIDTH, default 32, bus data width; only 32 is supported.
REQ-003 Parameter TIMEOUT, default 16, maximum number of ACCESS cycles waited for pready.
REQ-004 pclk  input  1  the single clock; all state is updated on its rising edge.
REQ-005 prst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  1  CPU request present.
REQ-007 req_ready  output  1  request accepted this cycle.
REQ-008 req_addr  input  ADDR_WIDTH  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 req_write  input  1  1 = store, 0 = load.
REQ-011 req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-012 req_unsigned  input  1  load zero-extends when set, sign-extends when clear.
REQ-013 rsp_valid  output  1  one-cycle response pulse.
REQ-014 rsp_rdata  output  32  load result, already extended; 0 for stores and errors.
REQ-015 rsp_err  output  1  error flag, qualified by rsp_valid.
REQ-016 paddr  output  ADDR_WIDTH  bus address, equal to req_addr.
REQ-017 pdata  output  32  bus write data, lane-shifted.
REQ-018 prdata  input  32  bus read data; only lanes enabled by pstb are meaningful.
REQ-019 psel, penable, pwrite  output  1 each  bus control.
REQ-020 pstb  output  4  byte-lane strobes, driven for reads and writes alike.
REQ-021 pready, perr  input  1 each  completer handshake and error.

Function
REQ-022 The FSM SHALL have exactly four states: IDLE, SETUP, ACCESS and RESP.
REQ-023 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid=1 and req_ready=1.
REQ-024 On acceptance, address, data, size, write and unsigned SHALL be registered; later changes to req_* SHALL have no effect until the next acceptance.
REQ-025 Misalignment is defined as: half with addr[0]=1; word with addr[1:0]!=0; or req_size=11.
REQ-026 An accepted misaligned request SHALL go IDLE->RESP with rsp_err=1, with no bus activity (psel stays 0).
REQ-027 An accepted aligned request SHALL go IDLE->SETUP; SETUP SHALL drive psel=1, penable=0 for exactly one cycle, then go to ACCESS.
REQ-028 ACCESS SHALL drive psel=1 and penable=1, and SHALL hold paddr, pdata, pwrite and pstb stable from SETUP until ACCESS exits.
REQ-029 In ACCESS with pready=1, the block SHALL capture prdata and perr and go to RESP.
REQ-030 A cycle counter SHALL clear on entry to ACCESS; if TIMEOUT cycles elapse without pready, the block SHALL go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-031 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; back-to-back requests therefore have at least one IDLE cycle between them.
REQ-032 Strobes: byte -> 4'b0001<<addr[1:0]; half -> 4'b0011<<addr[1:0]; word -> 4'b1111.
REQ-033 Write data: pdata = req_wdata shifted left by 8*addr[1:0]; pdata lanes with pstb=0 SHALL be 0.
REQ-034 Read data: shift prdata right by 8*addr[1:0], then truncate to the access size, then zero-extend or sign-extend per req_unsigned.
REQ-035 When perr=1 is captured, rsp_err SHALL be 1 and rsp_rdata SHALL be 0, for loads and stores alike.
REQ-036 Outside SETUP and ACCESS, psel, penable, pwrite and pstb SHALL be 0.
REQ-037 Nominal latency with a zero-wait completer is: accept at T0, SETUP at T1, ACCESS at T2, and RESP no earlier than T3.

Reset
REQ-038 While prst=1, regardless of the clock, the FSM SHALL be IDLE and every output SHALL be 0 except req_ready, which SHALL be 1 after release.
REQ-039 Asserting prst mid-transaction SHALL abort the transaction immediately: psel and penable drop in the same cycle, and no rsp_valid pulse is emitted for the aborted request.
REQ-040 Reset SHALL clear the timeout counter and all captured data.

Verification
REQ-041 Word store: addr 0x10, data 0xDEADBEEF, completer pready one cycle after ACCESS entry -> pstb=1111, pdata=0xDEADBEEF, rsp_valid at T4, rsp_err=0.
REQ-042 Signed byte load: addr 0x13, prdata=0x80xxxxxx -> pstb=1000, rsp_rdata=0xFFFFFF80; with req_unsigned=1 -> rsp_rdata=0x00000080.
REQ-043 Half store: addr 0x22, data 0x0000BEEF -> pstb=1100, pdata=0xBEEF0000; a half access at addr 0x21 -> rsp_err=1, psel never asserted.
REQ-044 Completer holds pready=0, TIMEOUT=16 -> psel high for exactly 17 cycles (SETUP plus 16 ACCESS), then rsp_err=1, rsp_rdata=0.
REQ-045 perr=1 returned with pready -> rsp_err=1, rsp_rdata=0; next request is accepted normally.
REQ-046 prst pulsed during ACCESS -> psel=0 within the same cycle, no rsp_valid, req_ready=1 after release.
